// File: rtl/ifetch_bp_pkg.sv
// Shared definitions for the ifetch_bp fetch unit: RISC-V control-flow
// opcodes, 2-bit bimodal counter encodings, boolean constants, FSM state
// type, the fetch-queue entry payload and a link-register helper.
package ifetch_bp_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [1:0] CTR_SNT = 2'b00;  // strongly not-taken
    localparam logic [1:0] CTR_WNT = 2'b01;  // weakly not-taken
    localparam logic [1:0] CTR_WT  = 2'b10;  // weakly taken
    localparam logic [1:0] CTR_ST  = 2'b11;  // strongly taken

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef enum logic {
        ST_FETCH     = 1'b0,
        ST_WAIT_JALR = 1'b1
    } state_e;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pred_pc;
        logic            pred_taken;
    } fq_entry_t;

    // x1 (ra) and x5 (t0) are the ABI link registers
    function automatic logic is_link(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd5);
    endfunction

endpackage

// File: rtl/ifetch_predecode.sv
// Combinational predecoder for one returned instruction word.
// Ports:
//   inst_i       - raw 32-bit instruction
//   is_branch_o  - conditional branch
//   is_jal_o     - JAL
//   is_jalr_o    - JALR
//   rd_o, rs1_o  - register fields
//   imm_b_o/imm_j_o/imm_i_o - sign-extended B/J/I immediates
module ifetch_predecode
    import ifetch_bp_pkg::*;
(
    input  logic [31:0] inst_i,
    output logic        is_branch_o,
    output logic        is_jal_o,
    output logic        is_jalr_o,
    output logic [4:0]  rd_o,
    output logic [4:0]  rs1_o,
    output logic [31:0] imm_b_o,
    output logic [31:0] imm_j_o,
    output logic [31:0] imm_i_o
);

    assign is_branch_o = (inst_i[6:0] == OPC_BRANCH);
    assign is_jal_o    = (inst_i[6:0] == OPC_JAL);
    assign is_jalr_o   = (inst_i[6:0] == OPC_JALR);
    assign rd_o        = inst_i[11:7];
    assign rs1_o       = inst_i[19:15];

    assign imm_b_o = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
    assign imm_j_o = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};
    assign imm_i_o = {{20{inst_i[31]}}, inst_i[31:20]};

endmodule

// File: rtl/ifetch_bp.sv
// Instruction-fetch unit with bimodal branch prediction and a decoupling
// fetch queue between the icache and decode.
// Optional feature: define IFETCH_RAS_EN to add a return-address stack
// that predicts returns instead of stalling in WAIT_JALR.
// Ports:
//   clk, rst, rdy               - clock, async active-high reset, global enable
//   ic_req/ic_addr/ic_flush     - icache request, address, drop pulse
//   ic_valid/ic_inst            - icache response
//   fq_valid/fq_ready/fq_*      - fetch-queue head handshake and payload
//   rob_redirect/rob_redirect_pc- misprediction redirect
//   br_valid/br_pc/br_taken     - committed branch outcome for BHT training
//   jalr_valid/jalr_target      - resolution of a stalled JALR
module ifetch_bp
    import ifetch_bp_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0,
    parameter int unsigned BHT_IDX_W = 7,
    parameter int unsigned FQ_DEPTH  = 4,
    parameter int unsigned RAS_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    output logic        ic_req,
    output logic [31:0] ic_addr,
    input  logic        ic_valid,
    input  logic [31:0] ic_inst,
    output logic        ic_flush,
    output logic        fq_valid,
    input  logic        fq_ready,
    output logic [31:0] fq_inst,
    output logic [31:0] fq_pc,
    output logic [31:0] fq_pred_pc,
    output logic        fq_pred_taken,
    input  logic        rob_redirect,
    input  logic [31:0] rob_redirect_pc,
    input  logic        br_valid,
    input  logic [31:0] br_pc,
    input  logic        br_taken,
    input  logic        jalr_valid,
    input  logic [31:0] jalr_target
);

    localparam int unsigned BHT_ENTRIES = 1 << BHT_IDX_W;
    localparam int unsigned FQ_PTR_W    = $clog2(FQ_DEPTH);
    localparam int unsigned FQ_CNT_W    = FQ_PTR_W + 1;
    localparam int unsigned RAS_PTR_W   = $clog2(RAS_DEPTH);
    localparam int unsigned RAS_CNT_W   = RAS_PTR_W + 1;

    // Elaboration-time parameter sanity
    if (FQ_DEPTH < 2 || (FQ_DEPTH & (FQ_DEPTH - 1)) != 0) begin : g_bad_fq
        $error("FQ_DEPTH must be a power of 2 and >= 2");
    end
    if (RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_ras
        $error("RAS_DEPTH must be a power of 2 and >= 2");
    end

    state_e                state_q, state_d;
    logic [31:0]           pc_q, pc_d;
    logic                  ic_req_q, ic_req_d;
    logic                  ic_flush_q, ic_flush_d;
    logic [FQ_PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FQ_CNT_W-1:0]   cnt_q, cnt_d;
    fq_entry_t             fq_mem_q [FQ_DEPTH];
    logic [1:0]            bht_q [BHT_ENTRIES];

    logic                  fetch_ok, pop, push_en, go_wait, pred_taken;
    logic [31:0]           pred_pc;
    logic                  bht_we;
    logic [1:0]            bht_cur, bht_wdata;
    logic [BHT_IDX_W-1:0]  br_idx, fetch_idx;

    logic                  pd_is_branch, pd_is_jal, pd_is_jalr;
    logic [4:0]            pd_rd, pd_rs1;
    logic [31:0]           pd_imm_b, pd_imm_j, pd_imm_i;

    ifetch_predecode u_predecode (
        .inst_i      (ic_inst),
        .is_branch_o (pd_is_branch),
        .is_jal_o    (pd_is_jal),
        .is_jalr_o   (pd_is_jalr),
        .rd_o        (pd_rd),
        .rs1_o       (pd_rs1),
        .imm_b_o     (pd_imm_b),
        .imm_j_o     (pd_imm_j),
        .imm_i_o     (pd_imm_i)
    );

`ifdef IFETCH_RAS_EN
    logic [31:0]          ras_q [RAS_DEPTH];
    logic [RAS_PTR_W-1:0] ras_sp_q, ras_sp_d;
    logic [RAS_CNT_W-1:0] ras_cnt_q, ras_cnt_d;
    logic                 ras_push_req, ras_pop_req, ras_we;
`endif

    assign br_idx    = br_pc[BHT_IDX_W+1:2];
    assign fetch_idx = pc_q[BHT_IDX_W+1:2];

    // Bits intentionally left unused by this configuration
    logic unused_ok;
    assign unused_ok = ^{br_pc[31:BHT_IDX_W+2], br_pc[1:0], pd_imm_i, pd_rd, pd_rs1};

    // Next-state: prediction, queue bookkeeping, redirect, JALR resolution
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ic_flush_d = FALSE;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        push_en    = FALSE;
        go_wait    = FALSE;
        pred_pc    = pc_q + 32'd4;
        pred_taken = FALSE;
        bht_we     = br_valid;
        bht_cur    = bht_q[br_idx];
        bht_wdata  = bht_cur;
`ifdef IFETCH_RAS_EN
        ras_push_req = FALSE;
        ras_pop_req  = FALSE;
        ras_we       = FALSE;
        ras_sp_d     = ras_sp_q;
        ras_cnt_d    = ras_cnt_q;
`endif
        // An icache response during the flush cycle belongs to the dropped request
        fetch_ok = ic_valid && ic_req_q && !ic_flush_q;
        pop      = (cnt_q != '0) && fq_ready;

        // Saturating 2-bit counter training
        if (br_taken) begin
            bht_wdata = (bht_cur == CTR_ST) ? CTR_ST : bht_cur + 2'd1;
        end else begin
            bht_wdata = (bht_cur == CTR_SNT) ? CTR_SNT : bht_cur - 2'd1;
        end

        // Predecode-driven next-PC prediction
        if (pd_is_jal) begin
            pred_pc    = pc_q + pd_imm_j;
            pred_taken = TRUE;
        end else if (pd_is_branch) begin
            if (bht_q[fetch_idx] >= CTR_WT) begin
                pred_pc    = pc_q + pd_imm_b;
                pred_taken = TRUE;
            end
        end else if (pd_is_jalr) begin
`ifdef IFETCH_RAS_EN
            if (pd_rd == 5'd0 && is_link(pd_rs1) && ras_cnt_q != '0) begin
                ras_pop_req = TRUE;
                pred_pc     = ras_q[ras_sp_q - RAS_PTR_W'(1)];
                pred_taken  = TRUE;
            end else begin
                go_wait = TRUE;
            end
`else
            go_wait = TRUE;
`endif
        end
`ifdef IFETCH_RAS_EN
        ras_push_req = (pd_is_jal || pd_is_jalr) && is_link(pd_rd);
`endif

        if (rob_redirect) begin
            pc_d       = rob_redirect_pc;
            state_d    = ST_FETCH;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            cnt_d      = '0;
            ic_flush_d = TRUE;
        end else begin
            if (fetch_ok) begin
                push_en  = TRUE;
                wr_ptr_d = wr_ptr_q + FQ_PTR_W'(1);
                pc_d     = pred_pc;
                if (go_wait) begin
                    state_d = ST_WAIT_JALR;
                end
`ifdef IFETCH_RAS_EN
                // Circular stack: a push when full overwrites the oldest entry
                if (ras_push_req) begin
                    ras_we   = TRUE;
                    ras_sp_d = ras_sp_q + RAS_PTR_W'(1);
                    if (ras_cnt_q != RAS_CNT_W'(RAS_DEPTH)) begin
                        ras_cnt_d = ras_cnt_q + RAS_CNT_W'(1);
                    end
                end else if (ras_pop_req) begin
                    ras_sp_d  = ras_sp_q - RAS_PTR_W'(1);
                    ras_cnt_d = ras_cnt_q - RAS_CNT_W'(1);
                end
`endif
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + FQ_PTR_W'(1);
            end
            cnt_d = cnt_q + FQ_CNT_W'(push_en) - FQ_CNT_W'(pop);
            if (state_q == ST_WAIT_JALR && jalr_valid) begin
                pc_d    = jalr_target;
                state_d = ST_FETCH;
            end
        end

        // Occupancy includes the in-flight request, so allow one only below depth
        ic_req_d = (state_d == ST_FETCH) && (cnt_d < FQ_CNT_W'(FQ_DEPTH));
    end

    // Control state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_FETCH;
            pc_q       <= RESET_PC;
            ic_req_q   <= FALSE;
            ic_flush_q <= FALSE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
        end else if (rdy) begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ic_req_q   <= ic_req_d;
            ic_flush_q <= ic_flush_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
        end
    end

    // Fetch-queue storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(FQ_DEPTH); i++) fq_mem_q[i] <= '0;
        end else if (rdy && push_en) begin
            fq_mem_q[wr_ptr_q] <= '{inst: ic_inst, pc: pc_q, pred_pc: pred_pc, pred_taken: pred_taken};
        end
    end

    // Branch history table
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(BHT_ENTRIES); i++) bht_q[i] <= CTR_WNT;
        end else if (rdy && bht_we) begin
            bht_q[br_idx] <= bht_wdata;
        end
    end

`ifdef IFETCH_RAS_EN
    // Return-address stack (not repaired on redirect)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(RAS_DEPTH); i++) ras_q[i] <= '0;
            ras_sp_q  <= '0;
            ras_cnt_q <= '0;
        end else if (rdy) begin
            if (ras_we) ras_q[ras_sp_q] <= pc_q + 32'd4;
            ras_sp_q  <= ras_sp_d;
            ras_cnt_q <= ras_cnt_d;
        end
    end
`endif

    assign ic_req        = ic_req_q && rdy;
    assign ic_addr       = pc_q;
    assign ic_flush      = ic_flush_q;
    assign fq_valid      = (cnt_q != '0);
    assign fq_inst       = fq_mem_q[rd_ptr_q].inst;
    assign fq_pc         = fq_mem_q[rd_ptr_q].pc;
    assign fq_pred_pc    = fq_mem_q[rd_ptr_q].pred_pc;
    assign fq_pred_taken = fq_mem_q[rd_ptr_q].pred_taken;

endmodule

// File: doc/ifetch_bp.md
# ifetch_bp

Parametrised instruction-fetch unit with bimodal branch prediction and a decoupling fetch queue. It sits between the icache and the dispatch/decode stage. It generates fetch addresses and predecodes returned words to steer the next PC. Fetched instructions are buffered with their predicted next PC; the ROB drives redirect, branch-training and JALR-resolution inputs back into it.

## Interface
- `RESET_PC`, 32'h0, PC fetched first after reset
- `BHT_IDX_W`, 7, log2 of branch-history-table entries; index = `pc[BHT_IDX_W+1:2]`
- `FQ_DEPTH`, 4, fetch-queue entries, power of 2, ≥2
- `RAS_DEPTH`, 4, return-address-stack entries, used only with `IFETCH_RAS_EN`
- `clk` in 1, single clock, rising edge
- `rst` in 1, asynchronous active-high reset
- `rdy` in 1, global enable; low freezes all state
- `ic_req` out 1, fetch request; held with stable `ic_addr` until `ic_valid`
- `ic_addr` out 32, fetch address
- `ic_valid` in 1, instruction word returned for the outstanding request
- `ic_inst` in 32, returned word
- `ic_flush` out 1, one-cycle pulse telling icache to drop any in-flight request
- `fq_valid` out 1, queue head valid
- `fq_ready` in 1, consumer accepts head when `fq_valid && fq_ready`
- `fq_inst` out 32, head instruction word
- `fq_pc` out 32, head PC
- `fq_pred_pc` out 32, head predicted next PC
- `fq_pred_taken` out 1, head predicted taken (branch taken, JAL, RAS-predicted JALR)
- `rob_redirect` in 1, misprediction/flush
- `rob_redirect_pc` in 32, correct PC
- `br_valid` in 1, committed conditional branch outcome
- `br_pc` in 32, that branch's PC
- `br_taken` in 1, actual outcome
- `jalr_valid` in 1, stalled JALR resolved
- `jalr_target` in 32, resolved target

## Operation
- States: FETCH, WAIT_JALR. Reset: FETCH, `pc=RESET_PC`, queue empty, all BHT counters 2'b01, RAS empty.
- FETCH: `ic_req=1` iff queue occupancy + outstanding request < `FQ_DEPTH` (occupancy counts the request in flight). One outstanding request max.
- On `ic_valid`: predecode `ic_inst`, push {inst, pc, pred_pc, pred_taken}, then update `pc`:
  - JAL: pc+immJ, taken.
  - Branch: counter ≥2'b10 → pc+immB taken; else pc+4.
  - JALR: RAS prediction when enabled; otherwise enter WAIT_JALR with `pred_pc=pc+4` and `pred_taken=0`, and issue no requests.
  - Other instructions: pc+4.
- WAIT_JALR: `jalr_valid` → `pc=jalr_target`, go to FETCH. `jalr_valid` in FETCH is ignored.
- BHT training on `br_valid`: taken → saturating increment (max 2'b11); not taken → saturating decrement (min 2'b00).
- Redirect (highest priority):
  - `pc=rob_redirect_pc`, state FETCH, queue cleared, outstanding cleared, `ic_flush=1` next cycle.
  - `ic_valid`, `jalr_valid` and queue pop in the same cycle are discarded.
  - `br_valid` in the same cycle is still applied.
- Queue push and pop in the same cycle are legal at any occupancy. Pointers wrap modulo `FQ_DEPTH`.
- `rdy` low: no state changes, `ic_req=0`. The icache contract guarantees no `ic_valid` while `rdy` is low.

## Timing
- Reset values: `ic_req=0`, `ic_addr=RESET_PC`, `ic_flush=0`, `fq_valid=0`, other fq outputs 0.
- First cycle after `rst` falls: `ic_req=1`, `ic_addr=RESET_PC`.
- Latency:
  - `ic_valid` at cycle t → entry visible on `fq_*` at t+1.
  - Next `ic_req` with the new address at t+1.
- Redirect at t → `ic_addr=rob_redirect_pc`, `ic_req=1`, `fq_valid=0`, `ic_flush=1` at t+1. The icache returns no `ic_valid` for the dropped request after that flush cycle.
- BHT update from `br_valid` at t is visible to predictions at t+1. Same-cycle read and update sees the old value.
- `fq_*` outputs are registered from queue storage; there is no combinational path from `ic_*` to `fq_*`.

## Configuration
- `IFETCH_RAS_EN` defined:
  - JAL/JALR with rd ∈ {x1,x5} push pc+4. When full, push overwrites the oldest entry.
  - JALR with rd=x0 and rs1 ∈ {x1,x5} on a non-empty RAS pops and predicts the popped value, taken. Fetch continues.
  - Other JALR, or an empty RAS, enters WAIT_JALR.
  - The RAS is not repaired on redirect.
- Undefined: no RAS logic. Every JALR enters WAIT_JALR.

## Structure
- Shared defines: opcode constants (JAL 7'b1101111, JALR 7'b1100111, BRANCH 7'b1100011), counter encodings (strongly/weakly not-taken/taken), TRUE/FALSE.
- One sub-module, `ifetch_predecode`: combinational; outputs is_branch, is_jal, is_jalr, rd, rs1 and sign-extended immB/immJ/immI.
- Queue, BHT, RAS and FSM live in `ifetch_bp`.

## Test plan
- Reset, then words at 0,4,8 are non-control → `ic_addr` 0→4→8, queue holds pc 0/4/8 with `pred_pc` 4/8/12.
- BEQ at 0x10 with imm +0x20, counter 01 → pred 0x14. After two `br_valid` taken for 0x10, refetch → pred 0x30 taken. Three not-taken → counter saturates at 00.
- `fq_ready=0` with `FQ_DEPTH=4` → exactly 4 entries, then `ic_req=0`. One pop → exactly one new request.
- JALR at 0x40 (macro off) → WAIT_JALR, no `ic_req`. `jalr_valid` with 0x100 → next `ic_addr=0x100`.
- `rob_redirect` to 0x200 coincident with `ic_valid` and a queue pop → queue empty, word dropped, `ic_flush` pulse, `ic_addr=0x200`.
- Macro on: JAL rd=x1 at 0x80 → RAS push 0x84. Later `ret` → `pred_pc=0x84`, fetch continues without WAIT_JALR.
